// File: rtl/arm_run_pkg.sv
// Shared types and default parameter values for the core run controller.
// Optional feature macro (see arm_run_ctrl): ARM_RUN_CTRL_STALL_CNT_EN.
package arm_run_pkg;

    localparam int DEF_NUM_MODES  = 2;
    localparam int DEF_RST_CYCLES = 1;
    localparam int DEF_RUN_CYCLES = 205;
    localparam int DEF_CNT_W      = 16;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_CORE_RST = 3'd1,
        ST_RUN      = 3'd2,
        ST_RECORD   = 3'd3,
        ST_FINISH   = 3'd4
    } state_t;

endpackage

// File: rtl/arm_sat_counter.sv
// Saturating up-counter with synchronous clear; never wraps past all-ones.
module arm_sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] q
);

    logic [CNT_W-1:0] r_q;

    // Clear wins over increment; increment stops at the all-ones value.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_q <= '0;
        end else if (clr) begin
            r_q <= '0;
        end else if (inc && (r_q != {CNT_W{1'b1}})) begin
            r_q <= r_q + CNT_W'(1);
        end
    end

    assign q = r_q;

endmodule

// File: rtl/arm_run_ctrl.sv
// Sequences NUM_MODES reset/run windows of a core and records, per run,
// the cycles spent running and whether the run ended by timeout.
// Optional feature: define ARM_RUN_CTRL_STALL_CNT_EN to add core_stall input
// and res_stalls output (stalled RUN cycles per recorded run).
// Handshake: start is a one-cycle request honoured only in IDLE; res_valid and
// done are one-cycle pulses with no back-pressure; res_* hold between records.
module arm_run_ctrl
    import arm_run_pkg::*;
#(
    parameter int  NUM_MODES  = DEF_NUM_MODES,
    parameter int  RST_CYCLES = DEF_RST_CYCLES,
    parameter int  RUN_CYCLES = DEF_RUN_CYCLES,
    parameter int  CNT_W      = DEF_CNT_W,
    localparam int MW         = (NUM_MODES > 1) ? $clog2(NUM_MODES) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             core_halt,
`ifdef ARM_RUN_CTRL_STALL_CNT_EN
    input  logic             core_stall,
`endif
    output logic             core_rst_n,
    output logic             frwrd_en,
    output logic [MW-1:0]    mode_idx,
    output logic             busy,
    output logic             done,
    output logic             res_valid,
    output logic [MW-1:0]    res_mode,
    output logic [CNT_W-1:0] res_cycles,
    output logic             res_timeout
`ifdef ARM_RUN_CTRL_STALL_CNT_EN
    ,
    output logic [CNT_W-1:0] res_stalls
`endif
);

    state_t           r_state;
    logic [CNT_W-1:0] r_rst_cnt;
    logic [MW-1:0]    r_mode;
    logic             r_core_rst_n;
    logic             r_frwrd_en;
    logic             r_busy;
    logic             r_done;
    logic             r_res_valid;
    logic [MW-1:0]    r_res_mode;
    logic [CNT_W-1:0] r_res_cycles;
    logic             r_res_timeout;

    logic             w_in_run;
    logic [CNT_W-1:0] w_cyc_q;
    logic [CNT_W-1:0] w_cyc_now;
    logic             w_timeout_hit;
    logic             w_last_mode;
    logic [MW-1:0]    w_mode_next;

    // The counter holds completed RUN cycles; it is cleared outside RUN.
    assign w_in_run = (r_state == ST_RUN);

    arm_sat_counter #(.CNT_W(CNT_W)) u_cyc_cnt (
        .clk (clk),
        .rst (rst),
        .clr (!w_in_run),
        .inc (w_in_run),
        .q   (w_cyc_q)
    );

    // Count including the current RUN cycle, so the first RUN cycle reads 1.
    assign w_cyc_now     = (&w_cyc_q) ? w_cyc_q : w_cyc_q + CNT_W'(1);
    assign w_timeout_hit = (w_cyc_now >= CNT_W'(RUN_CYCLES));
    assign w_last_mode   = (r_mode == MW'(NUM_MODES - 1));
    assign w_mode_next   = r_mode + MW'(1);

`ifdef ARM_RUN_CTRL_STALL_CNT_EN
    logic [CNT_W-1:0] r_res_stalls;
    logic [CNT_W-1:0] w_stall_q;
    logic [CNT_W-1:0] w_stall_now;

    arm_sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk (clk),
        .rst (rst),
        .clr (!w_in_run),
        .inc (w_in_run && core_stall),
        .q   (w_stall_q)
    );

    assign w_stall_now = (core_stall && !(&w_stall_q)) ? w_stall_q + CNT_W'(1) : w_stall_q;
    assign res_stalls  = r_res_stalls;
`endif

    // Sequencer FSM with registered outputs; results are captured on RUN exit
    // so res_valid is high during the RECORD cycle itself.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state       <= ST_IDLE;
            r_rst_cnt     <= '0;
            r_mode        <= '0;
            r_core_rst_n  <= 1'b0;
            r_frwrd_en    <= 1'b0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_res_valid   <= 1'b0;
            r_res_mode    <= '0;
            r_res_cycles  <= '0;
            r_res_timeout <= 1'b0;
`ifdef ARM_RUN_CTRL_STALL_CNT_EN
            r_res_stalls  <= '0;
`endif
        end else begin
            r_res_valid <= 1'b0;
            r_done      <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    r_core_rst_n <= 1'b1;
                    r_busy       <= 1'b0;
                    if (start) begin
                        r_state      <= ST_CORE_RST;
                        r_mode       <= '0;
                        r_frwrd_en   <= 1'b0;
                        r_busy       <= 1'b1;
                        r_core_rst_n <= 1'b0;
                        r_rst_cnt    <= '0;
                    end
                end
                ST_CORE_RST: begin
                    if (r_rst_cnt == CNT_W'(RST_CYCLES - 1)) begin
                        r_state      <= ST_RUN;
                        r_core_rst_n <= 1'b1;
                        r_rst_cnt    <= '0;
                    end else begin
                        r_rst_cnt <= r_rst_cnt + CNT_W'(1);
                    end
                end
                ST_RUN: begin
                    if (core_halt || w_timeout_hit) begin
                        r_state       <= ST_RECORD;
                        r_res_valid   <= 1'b1;
                        r_res_mode    <= r_mode;
                        r_res_cycles  <= w_cyc_now;
                        r_res_timeout <= !core_halt;
`ifdef ARM_RUN_CTRL_STALL_CNT_EN
                        r_res_stalls  <= w_stall_now;
`endif
                    end
                end
                ST_RECORD: begin
                    if (w_last_mode) begin
                        r_state <= ST_FINISH;
                        r_done  <= 1'b1;
                    end else begin
                        r_state      <= ST_CORE_RST;
                        r_mode       <= w_mode_next;
                        r_frwrd_en   <= w_mode_next[0];
                        r_core_rst_n <= 1'b0;
                        r_rst_cnt    <= '0;
                    end
                end
                ST_FINISH: begin
                    r_state      <= ST_IDLE;
                    r_busy       <= 1'b0;
                    r_core_rst_n <= 1'b1;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign core_rst_n  = r_core_rst_n;
    assign frwrd_en    = r_frwrd_en;
    assign mode_idx    = r_mode;
    assign busy        = r_busy;
    assign done        = r_done;
    assign res_valid   = r_res_valid;
    assign res_mode    = r_res_mode;
    assign res_cycles  = r_res_cycles;
    assign res_timeout = r_res_timeout;

endmodule

// File: tb/tb_arm_run_ctrl.sv
// Directed bench for arm_run_ctrl (defaults: 2 modes, 1 reset cycle,
// 205-cycle timeout). Stall-counter checks are built when
// ARM_RUN_CTRL_STALL_CNT_EN is defined.
module tb_arm_run_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic        core_halt = 1'b0;
    logic        core_rst_n;
    logic        frwrd_en;
    logic [0:0]  mode_idx;
    logic        busy;
    logic        done;
    logic        res_valid;
    logic [0:0]  res_mode;
    logic [15:0] res_cycles;
    logic        res_timeout;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

`ifdef ARM_RUN_CTRL_STALL_CNT_EN
    logic        core_stall = 1'b0;
    logic [15:0] res_stalls;

    // Narrow instance for the saturation case.
    logic        start4 = 1'b0;
    logic        halt4 = 1'b0;
    logic        stall4 = 1'b1;
    logic        core_rst_n4, frwrd_en4, busy4, done4, res_valid4, res_timeout4;
    logic [0:0]  mode_idx4, res_mode4;
    logic [3:0]  res_cycles4, res_stalls4;

    arm_run_ctrl #(.NUM_MODES(2), .RST_CYCLES(1), .RUN_CYCLES(15), .CNT_W(4)) u_dut4 (
        .clk(clk), .rst(rst), .start(start4), .core_halt(halt4), .core_stall(stall4),
        .core_rst_n(core_rst_n4), .frwrd_en(frwrd_en4), .mode_idx(mode_idx4),
        .busy(busy4), .done(done4), .res_valid(res_valid4), .res_mode(res_mode4),
        .res_cycles(res_cycles4), .res_timeout(res_timeout4), .res_stalls(res_stalls4)
    );
`endif

    arm_run_ctrl #(.NUM_MODES(2), .RST_CYCLES(1), .RUN_CYCLES(205), .CNT_W(16)) u_dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .core_halt  (core_halt),
`ifdef ARM_RUN_CTRL_STALL_CNT_EN
        .core_stall (core_stall),
`endif
        .core_rst_n (core_rst_n),
        .frwrd_en   (frwrd_en),
        .mode_idx   (mode_idx),
        .busy       (busy),
        .done       (done),
        .res_valid  (res_valid),
        .res_mode   (res_mode),
        .res_cycles (res_cycles),
        .res_timeout(res_timeout)
`ifdef ARM_RUN_CTRL_STALL_CNT_EN
        ,
        .res_stalls (res_stalls)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, ".core_rst_n"},  32'(core_rst_n),  0);
        check({tag, ".frwrd_en"},    32'(frwrd_en),    0);
        check({tag, ".mode_idx"},    32'(mode_idx),    0);
        check({tag, ".busy"},        32'(busy),        0);
        check({tag, ".done"},        32'(done),        0);
        check({tag, ".res_valid"},   32'(res_valid),   0);
        check({tag, ".res_mode"},    32'(res_mode),    0);
        check({tag, ".res_cycles"},  32'(res_cycles),  0);
        check({tag, ".res_timeout"}, 32'(res_timeout), 0);
`ifdef ARM_RUN_CTRL_STALL_CNT_EN
        check({tag, ".res_stalls"},  32'(res_stalls),  0);
`endif
    endtask

    // Entered just after the edge into CORE_RST. Drives one run: core_halt at
    // RUN cycle halt_at, start at start_at, async reset at abort_at (0 = never),
    // core_stall on every third cycle up to stall_n stalls.
    task automatic do_run(input int halt_at, input int exp_mode, input int exp_cyc,
                          input int exp_to, input int start_at, input int abort_at,
                          input int stall_n);
        int  low;
        int  cyc;
        bit  got;
        check("run.mode_idx", 32'(mode_idx), 32'(exp_mode));
        check("run.frwrd_en", 32'(frwrd_en), 32'(exp_mode % 2));
        check("run.busy",     32'(busy),     1);
        low = 0;
        while (core_rst_n === 1'b0 && low < 100) begin
            low++;
            step();
        end
        check("run.rst_low_cycles", 32'(low), 1);
        cyc = 1;
        got = 1'b0;
        while (cyc <= 1000 && !got) begin
            if (cyc == abort_at) begin
                rst = 1'b0;
                #1;
                check_reset_vals("abort");
                return;
            end
            core_halt = (cyc == halt_at);
            start     = (cyc == start_at);
`ifdef ARM_RUN_CTRL_STALL_CNT_EN
            core_stall = (cyc <= 3 * stall_n) && (cyc % 3 == 0);
`endif
            step();
            if (res_valid === 1'b1) got = 1'b1;
            else cyc++;
        end
        core_halt = 1'b0;
        start     = 1'b0;
`ifdef ARM_RUN_CTRL_STALL_CNT_EN
        core_stall = 1'b0;
        check("rec.res_stalls", 32'(res_stalls), 32'(stall_n));
`endif
        check("rec.res_valid",   32'(res_valid),   1);
        check("rec.run_length",  32'(cyc),         32'(exp_cyc));
        check("rec.res_mode",    32'(res_mode),    32'(exp_mode));
        check("rec.res_cycles",  32'(res_cycles),  32'(exp_cyc));
        check("rec.res_timeout", 32'(res_timeout), 32'(exp_to));
        check("rec.done_low",    32'(done),        0);
        check("rec.frwrd_en",    32'(frwrd_en),    32'(exp_mode % 2));
    endtask

    task automatic check_finish(input int exp_cyc);
        check("fin.done",       32'(done),       1);
        check("fin.busy",       32'(busy),       1);
        check("fin.res_valid",  32'(res_valid),  0);
        check("fin.core_rst_n", 32'(core_rst_n), 1);
        check("fin.res_hold",   32'(res_cycles), 32'(exp_cyc));
        step();
        check("idle.done", 32'(done), 0);
        check("idle.busy", 32'(busy), 0);
    endtask

    initial begin
        // Power-on reset values before any clock edge.
        #1;
        check_reset_vals("por");
        step();
        check("por.held_core_rst_n", 32'(core_rst_n), 0);
        rst = 1'b1;
        step();
        step();
        check("rel.core_rst_n", 32'(core_rst_n), 1);
        check("rel.busy",       32'(busy),       0);

        // core_halt in IDLE does nothing.
        core_halt = 1'b1;
        step();
        step();
        core_halt = 1'b0;
        check("idle_halt.busy",      32'(busy),      0);
        check("idle_halt.res_valid", 32'(res_valid), 0);
        check("idle_halt.res_cyc",   32'(res_cycles), 0);

        // Halt path: run 0 halts at 37, run 1 at 29.
        start = 1'b1;
        step();
        start = 1'b0;
        do_run(37, 0, 37, 0, 0, 0, 0);
        step();
        check("halt.res_hold", 32'(res_cycles), 37);
        do_run(29, 1, 29, 0, 0, 0, 0);
        step();
        check_finish(29);

        // Timeout run with a stray start, then halt exactly on the limit.
        start = 1'b1;
        step();
        start = 1'b0;
        do_run(0, 0, 205, 1, 10, 0, 0);
        step();
        check("to.res_hold", 32'(res_cycles), 205);
        do_run(205, 1, 205, 0, 0, 0, 0);
        step();
        check_finish(205);
        step();
        step();
        check("to.no_restart", 32'(busy), 0);

        // Async reset at RUN cycle 50 of run 1 discards the run.
        start = 1'b1;
        step();
        start = 1'b0;
        do_run(10, 0, 10, 0, 0, 0, 0);
        step();
        do_run(0, 1, 0, 0, 0, 50, 0);
        step();
        step();
        check_reset_vals("abort_held");
        rst = 1'b1;
        step();
        check("abort_rel.core_rst_n", 32'(core_rst_n), 1);
        check("abort_rel.res_valid",  32'(res_valid),  0);
        start = 1'b1;
        step();
        start = 1'b0;
        do_run(5, 0, 5, 0, 0, 0, 0);
        step();
        do_run(3, 1, 3, 0, 0, 0, 0);
        step();
        check_finish(3);

`ifdef ARM_RUN_CTRL_STALL_CNT_EN
        // 12 stalls within a 40-cycle run, then a stall-free run.
        start = 1'b1;
        step();
        start = 1'b0;
        do_run(40, 0, 40, 0, 0, 0, 12);
        step();
        do_run(40, 1, 40, 0, 0, 0, 0);
        step();
        check_finish(40);

        // Narrow counter: 15 stalled cycles in a 15-cycle timeout run.
        begin
            int w;
            start4 = 1'b1;
            step();
            start4 = 1'b0;
            w = 0;
            while (res_valid4 !== 1'b1 && w < 100) begin
                w++;
                step();
            end
            check("sat.res_valid",   32'(res_valid4),   1);
            check("sat.res_stalls",  32'(res_stalls4),  15);
            check("sat.res_cycles",  32'(res_cycles4),  15);
            check("sat.res_timeout", 32'(res_timeout4), 1);
        end
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/arm_run_ctrl.md
ARM_RUN_CTRL -- requirements
Module: arm_run_ctrl

Interface
REQ-001 SHALL have parameter NUM_MODES, default 2, meaning the number of core runs per sequence; mode index m (0..NUM_MODES-1) is the run number.
REQ-002 SHALL have parameter RST_CYCLES, default 1, meaning the number of cycles core_rst_n is held low per run (>=1).
REQ-003 SHALL have parameter RUN_CYCLES, default 205, meaning the timeout in cycles per run (>=1).
REQ-004 SHALL have parameter CNT_W, default 16, meaning the cycle-counter width; RUN_CYCLES SHALL be < 2^CNT_W.
REQ-005 SHALL have ports in this order:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle sequence-start pulse, sampled only in IDLE.
- core_halt  in  1  core signals the end of its program.
- core_rst_n  out  1  active-low reset to the core under control.
- frwrd_en  out  1  forwarding enable to the core, equal to mode_idx[0].
- mode_idx  out  $clog2(NUM_MODES) (min 1)  the current run index.
- busy  out  1  a sequence is in progress.
- done  out  1  one-cycle pulse when the last run is recorded.
- res_valid  out  1  one-cycle pulse per recorded run.
- res_mode  out  as mode_idx  the mode of the recorded run.
- res_cycles  out  CNT_W  cycles spent in RUN for the recorded run.
- res_timeout  out  1  the recorded run ended by timeout rather than by core_halt.

Function
REQ-006 SHALL implement the FSM states IDLE, CORE_RST, RUN, RECORD and FINISH.
REQ-007 IDLE SHALL move to CORE_RST on start=1, with mode_idx=0, busy=1 and all counters cleared.
REQ-008 CORE_RST SHALL drive core_rst_n=0 for exactly RST_CYCLES cycles, then move to RUN.
REQ-009 RUN SHALL drive core_rst_n=1 and increment the cycle counter every cycle, beginning at 1 on the first RUN cycle.
REQ-010 RUN SHALL move to RECORD when core_halt=1 or when the counter reaches RUN_CYCLES; core_halt has priority when both occur in the same cycle, and res_timeout=0 in that case.
REQ-011 core_halt SHALL be ignored outside RUN.
REQ-012 RECORD SHALL last one cycle and drive res_valid=1 with res_mode=mode_idx, res_cycles=the counter and res_timeout.
REQ-013 RECORD SHALL then go to CORE_RST with mode_idx+1, or to FINISH if mode_idx=NUM_MODES-1.
REQ-014 FINISH SHALL last one cycle, drive done=1, hold core_rst_n=1, and return to IDLE with busy=0.
REQ-015 res_* SHALL hold their values after RECORD until the next RECORD or until reset.
REQ-016 frwrd_en SHALL change only on the entry to CORE_RST, so it is stable for the core's entire reset and run window.
REQ-017 start SHALL be ignored while busy=1; there is no abort input.
REQ-018 The counter SHALL saturate at 2^CNT_W-1 and SHALL never wrap.

Reset
REQ-019 rst=0 SHALL asynchronously force state IDLE, core_rst_n=0, frwrd_en=0, mode_idx=0, busy=0, done=0, res_valid=0, res_mode=0, res_cycles=0, res_timeout=0 and counters=0.
REQ-020 core_rst_n SHALL go to 1 on the first clk edge after rst deasserts, and SHALL be 1 in IDLE.
REQ-021 rst asserted mid-run SHALL discard the partial run with no res_valid.

Configuration
REQ-022 Macro ARM_RUN_CTRL_STALL_CNT_EN, when defined, SHALL add input core_stall (1 bit) and output res_stalls (CNT_W bits, saturating), which counts RUN cycles with core_stall=1, is captured in RECORD and is reset to 0.
REQ-023 When the macro is undefined, those ports SHALL be absent and the rest of the behaviour SHALL be unchanged.

Structure
REQ-024 Package arm_run_pkg SHALL hold the state enum and the default parameter constants.
REQ-025 Sub-module arm_sat_counter (parameter CNT_W; ports clr, inc, q) SHALL be used for the cycle counter and for the stall counter.
REQ-026 The FSM and result registers SHALL be in arm_run_ctrl itself.

Verification
REQ-027 Reset check: with rst=0 at time 0, all outputs SHALL match REQ-019; after rst=1 and two edges, core_rst_n=1 and busy=0.
REQ-028 Halt path (NUM_MODES=2, RST_CYCLES=1): start; core_halt rises at RUN cycle 37 in run 0 and at cycle 29 in run 1 -> res_valid pulses with (mode 0, 37, timeout 0) then (mode 1, 29, 0); frwrd_en=0 then 1; done pulses one cycle after the second RECORD.
REQ-029 Timeout path (RUN_CYCLES=205, core_halt held 0) -> each run records res_cycles=205 with res_timeout=1; core_rst_n is low for exactly RST_CYCLES cycles before each run.
REQ-030 Simultaneous events: core_halt=1 on exactly cycle 205 -> res_cycles=205 with res_timeout=0; start pulsed mid-sequence -> no effect; core_halt pulsed in IDLE -> no effect.
REQ-031 Reset mid-run: rst=0 at RUN cycle 50 of run 1 -> no res_valid, all outputs at reset values; a fresh start then begins again at mode 0.
REQ-032 With ARM_RUN_CTRL_STALL_CNT_EN defined and core_stall=1 on 12 of 40 RUN cycles -> res_stalls=12; with CNT_W=4, RUN_CYCLES=15 and core_stall held 1 -> res_stalls=15 with no wrap.
